mem_port_arbiter: RTL

// - Shares the CPU's single memory port between instruction fetch (IF) and the data/load-store stage (D).
// - Sits between the pipeline front/back ends and the memory interface.
// - Latches the winning request, holds it stable on the memory port until acknowledged, then returns a completion pulse.
// - D has priority; a starvation counter guarantees IF forward progress.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, D and memory-side signals of the memory port arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the load/store stage (D).
// D has priority; after MAX_WAIT consecutive lost arbitrations IF is forced to win.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    localparam int WCW       = $clog2(MAX_WAIT + 1)
) (
    input  logic           clk,
    input  logic           reset,
    mem_port_arbiter_if.master bus,
    output logic           busy,
    output logic [1:0]     dbg_state_o,
    output logic [WCW-1:0] dbg_wait_cnt_o
);

    // Handshake: a request is accepted in the IDLE cycle where its gnt pulses;
    // the memory side holds mem_req and its fields stable until the cycle mem_ack=1,
    // and the owner sees exactly one rvalid pulse in the following cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);
    localparam logic           OWNER_IF   = 1'b0;
    localparam logic           OWNER_D    = 1'b1;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [WCW-1:0]        wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic if_gnt, d_gnt, d_win, if_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_IF;
            wait_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        d_win   = 1'b0;
        if_win  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Gating with reset keeps the combinational grants low while reset is held.
                if (reset) begin
                    d_win  = bus.d_req && !(bus.if_req && (wait_q == MAX_WAIT_C));
                    if_win = bus.if_req && !d_win;
                end
                if (d_win) begin
                    d_gnt   = 1'b1;
                    owner_d = OWNER_D;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    if (bus.if_req && (wait_q != MAX_WAIT_C)) wait_d = wait_q + WCW'(1);
                    state_d = ST_BUSY;
                end else if (if_win) begin
                    if_gnt  = 1'b1;
                    owner_d = OWNER_IF;
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wait_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    if (!we_q) rdata_d = bus.mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = (state_q == ST_RESP) && (owner_q == OWNER_IF);
    assign bus.d_rvalid  = (state_q == ST_RESP) && (owner_q == OWNER_D);
    assign bus.if_rdata  = rdata_q;
    assign bus.d_rdata   = rdata_q;

    // Memory fields are forced to zero whenever no request is presented.
    assign bus.mem_req   = (state_q == ST_BUSY);
    assign bus.mem_we    = (state_q == ST_BUSY) ? we_q    : 1'b0;
    assign bus.mem_addr  = (state_q == ST_BUSY) ? addr_q  : '0;
    assign bus.mem_wdata = (state_q == ST_BUSY) ? wdata_q : '0;

    assign busy           = (state_q != ST_IDLE);
    assign dbg_state_o    = state_q;
    assign dbg_wait_cnt_o = wait_q;

endmodule
